// File: rtl/extmem_tx_pkg.sv
// Shared types and constants for the external-memory store UART tap.
// Latency: n/a (types, constants and a byte-select helper only).
// Backpressure: n/a.
package extmem_tx_pkg;

  localparam int EXT_ADDR_W       = 9;
  localparam int EXT_DATA_W       = 32;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int BYTES_PER_RECORD = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  typedef struct packed {
    logic [EXT_ADDR_W-1:0] addr;
    logic [EXT_DATA_W-1:0] data;
  } extmem_rec_t;

  // Byte idx of the on-wire record: sync, addr MSB, addr low byte, data MSB first.
  function automatic logic [7:0] rec_byte(input extmem_rec_t rec, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = {7'b0, rec.addr[8]};
      3'd2:    b = rec.addr[7:0];
      3'd3:    b = rec.data[31:24];
      3'd4:    b = rec.data[23:16];
      3'd5:    b = rec.data[15:8];
      3'd6:    b = rec.data[7:0];
      default: b = SYNC_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/extmem_fifo.sv
// Synchronous FIFO of captured store records.
// Latency: a pushed record is visible at head_o the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens on the same edge; pop ignored when empty.
// Ports: clk/reset (async active-low); push_i + push_dat_i write; pop_i consumes head_o;
//        full_o, empty_o, count_o report occupancy.
module extmem_fifo
  import extmem_tx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  extmem_rec_t              push_dat_i,
  input  logic                     pop_i,
  output extmem_rec_t              head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  extmem_rec_t        mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the slot the push lands in when full (wr_ptr == rd_ptr).
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/extmem_uart_tx.sv
// Captures data-memory stores and streams each as a 7-byte UART record (A5, addr, data).
// Latency: store at edge N is popped at N+1; tx start bit begins at edge N+2.
// Backpressure: none upstream; stores arriving with the FIFO full are dropped and counted.
// Ports: clk, reset (async active-low); wr_valid/wr_addr/wr_data store strobe;
//        tx serial line (idle high), busy, fifo_full, drop_cnt (saturating at 255).
// Build option: define EXTMEM_TX_PARITY_EN to append an even-parity bit to each frame.
module extmem_uart_tx
  import extmem_tx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = EXT_ADDR_W,
  parameter int DATA_W     = EXT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              tx,
  output logic              busy,
  output logic              fifo_full,
  output logic [7:0]        drop_cnt
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_RECORD - 1);

  tx_state_t              state_q, state_d;
  logic [BIT_CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [2:0]             byte_idx_q, byte_idx_d;
  extmem_rec_t            rec_q, rec_d;
  logic                   tx_q, tx_d;
  logic                   busy_q;
  logic [7:0]             drop_q, drop_d;

  extmem_rec_t                   wr_rec, fifo_head;
  logic                          push, pop, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          bit_done;
  logic [7:0]                    cur_byte;

  assign wr_rec.addr = wr_addr;
  assign wr_rec.data = wr_data;

  assign push = wr_valid & (~fifo_full | pop);

  extmem_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (wr_rec),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign bit_done = (clk_cnt_q == BIT_CNT_MAX);
  assign cur_byte = rec_byte(rec_q, byte_idx_q);

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    rec_d      = rec_q;
    pop        = 1'b0;
    tx_d       = 1'b1;

    if (state_q != IDLE) clk_cnt_d = bit_done ? '0 : clk_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          rec_d      = fifo_head;
          byte_idx_d = '0;
          clk_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        tx_d = cur_byte[bit_idx_q];
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
`ifdef EXTMEM_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef EXTMEM_TX_PARITY_EN
      PARITY: begin
        tx_d = ^cur_byte;
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          if (byte_idx_q != LAST_BYTE) begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = START;
          end else if (!fifo_empty) begin
            // Chain straight into the next record without an idle gap.
            pop        = 1'b1;
            rec_d      = fifo_head;
            byte_idx_d = '0;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (wr_valid && !push && drop_q != 8'hFF) drop_d = drop_q + 1'b1;
  end

  // tx and busy are registered from the current state, so both trail the
  // state register by one cycle and stay aligned with each other.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      rec_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      rec_q      <= rec_d;
      tx_q       <= tx_d;
      busy_q     <= (state_q != IDLE) | (fifo_count != '0);
      drop_q     <= drop_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_q;

endmodule

// File: doc/extmem_uart_tx.md
Name: extmem_uart_tx

Overview:
- Consumer of the processor's external-memory store port.
- Every store strobe (9-bit word address plus 32-bit data) is captured into a small FIFO.
- Each captured store is sent off-chip as a fixed 7-byte UART record (8N1, LSB first), so a host can observe memory writes in real time.
- Sits beside the data memory and takes the same address/data/write-enable the datapath drives to it.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_HZ/BAUD (integer division; must be ≥ 2).
- FIFO_DEPTH, 8, number of captured records; power of two, ≥ 2.
- ADDR_W, 9, store address width.
- DATA_W, 32, store data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  one-cycle store strobe (data memory write enable).
- wr_addr  in  ADDR_W  store word address.
- wr_data  in  DATA_W  store data.
- tx  out  1  UART serial line; idle high.
- busy  out  1  high while a record is in flight or the FIFO is non-empty.
- fifo_full  out  1  FIFO holds FIFO_DEPTH records.
- drop_cnt  out  8  saturating count of stores lost to overflow.

Behaviour:
- Reset (reset=0, asynchronous): tx=1, busy=0, fifo_full=0, drop_cnt=0, FIFO emptied, FSM=IDLE, all counters 0. Applies immediately, including mid-frame; the partial frame is abandoned.
- Capture:
  - A store is pushed on the rising edge where wr_valid=1 and (count<FIFO_DEPTH, or a pop occurs on the same edge).
  - Otherwise the store is dropped and drop_cnt increments, saturating at 255.
  - wr_addr and wr_data are sampled only on that edge.
- Record format, byte order: 0xA5 sync; {7'b0, addr[8]}; addr[7:0]; data[31:24]; data[23:16]; data[15:8]; data[7:0].
- Frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty, pop the head into the record register, set byte_idx=0, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=current byte[bit_idx]. After CLKS_PER_BIT cycles, increment bit_idx; after bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte_idx<6: increment byte_idx and go to START.
    - Else, if FIFO non-empty: pop, byte_idx=0, go to START (no idle gap).
    - Else: go to IDLE.
- Latency: with the block idle and the FIFO empty, a store sampled at edge N is popped at edge N+1. tx is low from edge N+2 (registered tx).
- Record duration: 70·CLKS_PER_BIT cycles, or 77· with parity enabled.
- Outputs:
  - tx is driven from a flop; it never glitches.
  - busy = (state≠IDLE) | (count≠0).
  - fifo_full = (count==FIFO_DEPTH).
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

Optional Feature:
- EXTMEM_TX_PARITY_EN
  - Defined: a PARITY state is inserted between DATA and STOP. tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame is 11 bits.
  - Undefined: no PARITY state; 8N1 frame of 10 bits.

Decomposition:
- Package extmem_tx_pkg:
  - SYNC_BYTE = 8'hA5
  - BYTES_PER_RECORD = 7
  - tx_state_t enum: IDLE, START, DATA, PARITY, STOP
  - extmem_rec_t packed struct {addr[ADDR_W-1:0], data[DATA_W-1:0]}
- Sub-module extmem_fifo: synchronous FIFO of extmem_rec_t with push, pop, full, empty, count. Pop takes priority-neutral simultaneous push.

Test Plan (CLK_HZ=1000, BAUD=100, so CLKS_PER_BIT=10):
- Reset: hold reset=0 → tx=1, busy=0, fifo_full=0, drop_cnt=0. Release with no stores → tx stays 1 for 1000 cycles.
- Single store wr_addr=0x1F3, wr_data=0xDEADBEEF:
  - tx falls 2 cycles after the strobe edge.
  - Decoded bytes: A5, 01, F3, DE, AD, BE, EF.
  - Each bit lasts 10 cycles; busy deasserts 700 cycles after the first start edge.
- Ten strobes on consecutive cycles with distinct data:
  - 9 accepted, including the same-edge push/pop on cycle 1.
  - fifo_full=1 after the 9th; 10th dropped; drop_cnt=1.
  - 9 records transmitted back-to-back, in order.
- Reset asserted during byte 3 of a record → tx=1 within the same cycle, FIFO empty, drop_cnt=0. After release, no further transmission.
- 300 strobes while fifo_full held → drop_cnt saturates at 255 and does not wrap.
- With EXTMEM_TX_PARITY_EN:
  - Byte 0xA5 (four 1s) gives parity bit 0; byte 0x01 gives parity bit 1.
  - Each frame is 110 cycles.
